// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM state
// encodings, the default hold limit, and the rotating priority search.
package rr_arbiter_4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_GRANT = 2'b01
   } arb_state_e;

   localparam int DEFAULT_MAX_HOLD = 8;

   // Rotating priority search: checks ptr, ptr+1, ptr+2, ptr+3 (mod 4) and
   // returns {found, index} of the first set request bit in that order.
   function automatic logic [2:0] next_winner(input logic [3:0] req,
                                              input logic [1:0] ptr);
      logic       found;
      logic [1:0] idx;
      logic [1:0] win;
      found = 1'b0;
      win   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + k[1:0];
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

endpackage

// File: rtl/rr_arbiter_4_decoder.sv
// 2-to-4 one-hot decoder with an enable; output is all-zero when disabled.
module decoder_2_4 (
   input  logic [1:0] idx,
   input  logic       en,
   output logic [3:0] onehot
);

   // Expand the index to one-hot, forced to zero when not enabled
   always_comb begin
      onehot = 4'b0000;
      if (en) begin
         onehot = 4'b0001 << idx;
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter. The winner index and valid flag are
// registered; the one-hot grant is decoded from those registers only, so
// there is no combinational path from req to gnt. A requester holding the
// grant under contention is rotated out after MAX_HOLD cycles.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   localparam int HCW = $clog2(MAX_HOLD);
   localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

   arb_state_e     state_q, state_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [1:0]     gnt_idx_q, gnt_idx_d;
   logic           gnt_valid_q, gnt_valid_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

   logic [3:0]     search_req;
   logic [2:0]     win;
   logic           win_found;
   logic [1:0]     win_idx;

   // Candidate search: the current grantee is masked out so a handoff or
   // timeout always considers only the other three requesters
   always_comb begin
      search_req = req;
      if (gnt_valid_q) begin
         search_req = req & ~(4'b0001 << gnt_idx_q);
      end
      win       = next_winner(search_req, ptr_q);
      win_found = win[2];
      win_idx   = win[1:0];
   end

   // Next-state logic for arbitration, handoff, timeout and hold counting
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      hold_cnt_d  = hold_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d     = ST_GRANT;
               gnt_idx_d   = win_idx;
               gnt_valid_d = 1'b1;
               ptr_d       = win_idx + 2'd1;
               hold_cnt_d  = '0;
            end
         end
         ST_GRANT: begin
            if (!req[gnt_idx_q]) begin
               // Grantee released: hand off directly or go idle
               if (win_found) begin
                  gnt_idx_d  = win_idx;
                  ptr_d      = win_idx + 2'd1;
                  hold_cnt_d = '0;
               end else begin
                  state_d     = ST_IDLE;
                  gnt_idx_d   = 2'd0;
                  gnt_valid_d = 1'b0;
                  hold_cnt_d  = '0;
               end
            end else if (hold_cnt_q == HOLD_LAST) begin
               // Hold limit reached: rotate if anyone else waits, else restart
               if (win_found) begin
                  gnt_idx_d = win_idx;
                  ptr_d     = win_idx + 2'd1;
               end
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HCW'(1);
            end
         end
         default: begin
            state_d     = ST_IDLE;
            gnt_idx_d   = 2'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= 2'd0;
         gnt_idx_q   <= 2'd0;
         gnt_valid_q <= 1'b0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   decoder_2_4 u_decoder (
      .idx    (gnt_idx_q),
      .en     (gnt_valid_q),
      .onehot (gnt)
   );

   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed testbench for rr_arbiter_4 with MAX_HOLD = 8.
module tb_rr_arbiter_4;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;

   int checks;
   int failures;

   rr_arbiter_4 #(.MAX_HOLD(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 4'b0000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = 4'b1111;
      tick();
      tick();
      checks++;
      if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: gnt=%b idx=%0d valid=%b required gnt=0000 idx=0 valid=0",
                  gnt, gnt_idx, gnt_valid);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
         failures++;
         $display("FAIL reset_first_grant: gnt=%b idx=%0d valid=%b required gnt=0001 idx=0 valid=1",
                  gnt, gnt_idx, gnt_valid);
      end
      $display("test_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0000) begin
         failures++;
         $display("FAIL single_no_comb_path: gnt=%b required 0000", gnt);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (gnt !== 4'b0100 || gnt_idx !== 2'd2 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_hold cyc%0d: gnt=%b idx=%0d valid=%b required gnt=0100 idx=2 valid=1",
                     c, gnt, gnt_idx, gnt_valid);
         end
      end
      req = 4'b0000;
      tick();
      checks++;
      if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_release: gnt=%b idx=%0d valid=%b required gnt=0000 idx=0 valid=0",
                  gnt, gnt_idx, gnt_valid);
      end
      $display("test_single done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt;
      logic [1:0] exp_idx;
      do_reset();
      req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         tick();
         exp_idx = 2'((c / 8) % 4);
         exp_gnt = 4'b0001 << exp_idx;
         checks++;
         if (gnt !== exp_gnt || gnt_idx !== exp_idx) begin
            failures++;
            $display("FAIL round_robin cyc%0d: gnt=%b idx=%0d required gnt=%b idx=%0d",
                     c, gnt, gnt_idx, exp_gnt, exp_idx);
         end
      end
      $display("test_round_robin done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_handoff();
      do_reset();
      req = 4'b0010;
      tick();
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL handoff_setup: gnt=%b required 0010", gnt);
      end
      req = 4'b1001;
      tick();
      checks++;
      if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || gnt_valid !== 1'b1) begin
         failures++;
         $display("FAIL handoff_next: gnt=%b idx=%0d valid=%b required gnt=1000 idx=3 valid=1",
                  gnt, gnt_idx, gnt_valid);
      end
      $display("test_handoff done checks=%0d failures=%0d", checks, failures);
   endtask

   // Release handoff must restart the hold count for the new grantee
   task automatic test_handoff_hold();
      logic [3:0] exp_gnt;
      do_reset();
      req = 4'b0111;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001) begin
            failures++;
            $display("FAIL handoff_hold_first cyc%0d: gnt=%b required 0001", c, gnt);
         end
      end
      req = 4'b0110;
      for (int c = 0; c < 9; c++) begin
         tick();
         exp_gnt = (c < 8) ? 4'b0010 : 4'b0100;
         checks++;
         if (gnt !== exp_gnt) begin
            failures++;
            $display("FAIL handoff_hold_second cyc%0d: gnt=%b required %b", c, gnt, exp_gnt);
         end
      end
      $display("test_handoff_hold done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_timeout_alone();
      do_reset();
      req = 4'b0001;
      for (int c = 0; c < 20; c++) begin
         tick();
         checks++;
         if (gnt !== 4'b0001 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_alone cyc%0d: gnt=%b valid=%b required gnt=0001 valid=1",
                     c, gnt, gnt_valid);
         end
      end
      $display("test_timeout_alone done checks=%0d failures=%0d", checks, failures);
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      tick();
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL async_setup: gnt=%b required 0100", gnt);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (gnt !== 4'b0000 || gnt_idx !== 2'd0 || gnt_valid !== 1'b0) begin
         failures++;
         $display("FAIL async_clear: gnt=%b idx=%0d valid=%b required gnt=0000 idx=0 valid=0",
                  gnt, gnt_idx, gnt_valid);
      end
      req = 4'b1111;
      #1;
      rst = 1'b0;
      tick();
      checks++;
      if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
         failures++;
         $display("FAIL async_after: gnt=%b idx=%0d required gnt=0001 idx=0", gnt, gnt_idx);
      end
      $display("test_async_reset done checks=%0d failures=%0d", checks, failures);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      req      = 4'b0000;
      test_reset();
      test_single();
      test_round_robin();
      test_handoff();
      test_handoff_hold();
      test_timeout_alone();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

endmodule
